// File: rtl/i2c_slave_core.sv
// i2c_slave_core: I2C target that answers one 7-bit address, receives write bytes and returns read bytes
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR       = 7'h50,
  parameter bit         ACK_DATA_DEFAULT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       ack_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_req,
  output logic       addr_hit,
  output logic       start_det,
  output logic       stop_det,
  output logic       nack_det,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;
  state_t     state_q, state_d;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d, rx_data_q, rx_data_d;
  logic       rw_q, rw_d, ack_q, ack_d, oe_q, oe_d, busy_q, busy_d;
  logic       rv_pend_q, rv_pend_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic       hit_q, hit_d, start_q, start_d, stop_q, stop_d, nack_q, nack_d;
  logic       scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;
  logic [3:0] cnt_inc;
  logic [7:0] byte_in, tx_load;
  assign scl_s    = scl_q[1];
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_s & ~scl_q[2];
  assign scl_fall = ~scl_s & scl_q[2];
  assign sda_rise = sda_s & ~sda_q[2];
  assign sda_fall = ~sda_s & sda_q[2];
  assign start_c  = sda_fall & scl_s;
  assign stop_c   = sda_rise & scl_s;
  assign cnt_inc  = cnt_q == 4'd8 ? cnt_q : cnt_q + 4'd1;
  assign byte_in  = {shift_q[6:0], sda_s};
  assign tx_load  = tx_valid ? tx_data : 8'hFF;
  assign sda_oe    = oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign addr_hit  = hit_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign nack_det  = nack_q;
  assign busy      = busy_q;
  // Register the synchronisers, FSM state and all registered outputs; sync chains preset to an idle bus
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rv_pend_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      hit_q      <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], scl_i};
      sda_q      <= {sda_q[1:0], sda_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rv_pend_q  <= rv_pend_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      hit_q      <= hit_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      nack_q     <= nack_d;
    end
  end
  // Next-state logic: START/STOP override everything, otherwise SDA sampled on SCL rise and driven on SCL fall
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    rv_pend_d  = 1'b0;
    rx_valid_d = rv_pend_q;
    tx_req_d   = 1'b0;
    hit_d      = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    nack_d     = 1'b0;
    if (start_c) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      start_d = 1'b1;
    end else if (stop_c) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      stop_d  = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_inc;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            oe_d    = 1'b0;
            state_d = byte_in[7:1] == SLAVE_ADDR ? ADDR_ACK : IGNORE;
            hit_d   = byte_in[7:1] == SLAVE_ADDR;
            busy_d  = busy_q | (byte_in[7:1] == SLAVE_ADDR);
            rw_d    = sda_s;
          end
        end
        ADDR_ACK: begin
          tx_req_d = scl_rise & rw_q;
          if (scl_fall && cnt_q == 4'd0) begin
            oe_d  = 1'b1;
            cnt_d = 4'd1;
          end else if (scl_fall) begin
            cnt_d   = '0;
            state_d = rw_q ? RD_DATA : WR_DATA;
            tx_d    = tx_load;
            oe_d    = rw_q & ~tx_load[7];
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_inc;
          if (cnt_q == 4'd7) begin
            cnt_d     = '0;
            rx_data_d = byte_in;
            rv_pend_d = 1'b1;
            ack_d     = ack_en & ACK_DATA_DEFAULT;
            state_d   = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall && cnt_q == 4'd0) begin
          oe_d  = ack_q;
          cnt_d = 4'd1;
        end else if (scl_fall) begin
          oe_d    = 1'b0;
          cnt_d   = '0;
          state_d = WR_DATA;
        end
        RD_DATA: if (scl_rise) begin
          tx_d  = {tx_q[6:0], 1'b0};
          cnt_d = cnt_inc;
        end else if (scl_fall) begin
          tx_d    = cnt_q == 4'd0 ? tx_load : tx_q;
          oe_d    = cnt_q == 4'd0 ? ~tx_load[7] : cnt_q == 4'd8 ? 1'b0 : ~tx_q[7];
          cnt_d   = cnt_q == 4'd8 ? 4'd0 : cnt_q;
          state_d = cnt_q == 4'd8 ? RD_ACK : RD_DATA;
        end
        RD_ACK: if (scl_rise) begin
          cnt_d    = '0;
          nack_d   = sda_s;
          tx_req_d = ~sda_s;
          state_d  = sda_s ? IGNORE : RD_DATA;
        end
        IGNORE: oe_d = 1'b0;
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave_core.sv
// tb_i2c_slave_core: bus-level master driving i2c_slave_core against a transaction-level expectation model
module tb_i2c_slave_core;
  logic       clk = 1'b0, reset = 1'b1, scl_i = 1'b1, m_sda = 1'b1, sda_i;
  logic       sda_oe, rx_valid, ack_en = 1'b1, tx_valid = 1'b0, tx_req;
  logic       addr_hit, start_det, stop_det, nack_det, busy;
  logic [7:0] rx_data, tx_data = 8'h00, last_rx = 8'h00;
  int n_chk = 0, n_fail = 0;
  int n_hit = 0, n_start = 0, n_stop = 0, n_nack = 0, n_txreq = 0, n_rxv = 0, n_oe = 0;

  i2c_slave_core #(.SLAVE_ADDR(7'h50), .ACK_DATA_DEFAULT(1'b1)) dut (
    .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .ack_en(ack_en), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_req(tx_req), .addr_hit(addr_hit), .start_det(start_det),
    .stop_det(stop_det), .nack_det(nack_det), .busy(busy)
  );

  always #5 clk = ~clk;
  assign sda_i = m_sda & ~sda_oe;

  always @(negedge clk) begin
    if (addr_hit)  n_hit   <= n_hit + 1;
    if (start_det) n_start <= n_start + 1;
    if (stop_det)  n_stop  <= n_stop + 1;
    if (nack_det)  n_nack  <= n_nack + 1;
    if (tx_req)    n_txreq <= n_txreq + 1;
    if (sda_oe)    n_oe    <= n_oe + 1;
    if (rx_valid) begin
      n_rxv   <= n_rxv + 1;
      last_rx <= rx_data;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not end, required finish before 5ms");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start;
    m_sda = 1'b1; tick(5); scl_i = 1'b1; tick(5); m_sda = 1'b0; tick(5); scl_i = 1'b0; tick(5);
  endtask

  task automatic do_stop;
    m_sda = 1'b0; tick(5); scl_i = 1'b1; tick(5); m_sda = 1'b1; tick(10);
  endtask

  task automatic do_bit(input logic b, output logic r);
    m_sda = b; tick(5); scl_i = 1'b1; tick(5); r = sda_i; tick(5); scl_i = 1'b0; tick(5);
  endtask

  task automatic do_byte(input logic [7:0] mo, output logic [7:0] got);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      do_bit(mo[i], r);
      got[i] = r;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; tick(3);
    n_chk++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", sda_oe); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    n_chk++; if ({rx_valid, tx_req, addr_hit, start_det, stop_det, nack_det} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000000", {rx_valid, tx_req, addr_hit, start_det, stop_det, nack_det});
    end
    reset = 1'b0; tick(8);
    n_chk++; if (n_start + n_stop !== 0) begin n_fail++; $display("FAIL reset_release: got %0d bus events want 0", n_start + n_stop); end
  endtask

  task automatic test_write;
    logic [7:0] g; logic a; int h0, s0, p0, v0;
    h0 = n_hit; s0 = n_start; p0 = n_stop; v0 = n_rxv;
    do_start; do_byte(8'hA0, g); do_bit(1'b1, a);
    n_chk++; if (a !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: got %b want 0", a); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b want 1", busy); end
    do_byte(8'h3C, g);
    n_chk++; if (g !== 8'h3C) begin n_fail++; $display("FAIL wr_bus_data: got %h want 3c", g); end
    do_bit(1'b1, a);
    n_chk++; if (a !== 1'b0) begin n_fail++; $display("FAIL wr_data_ack: got %b want 0", a); end
    do_stop;
    n_chk++; if (rx_data !== 8'h3C || last_rx !== 8'h3C) begin n_fail++; $display("FAIL wr_rx: got %h/%h want 3c", rx_data, last_rx); end
    n_chk++; if (n_rxv - v0 !== 1) begin n_fail++; $display("FAIL wr_rxv: got %0d want 1", n_rxv - v0); end
    n_chk++; if (n_stop - p0 !== 1) begin n_fail++; $display("FAIL wr_stop: got %0d want 1", n_stop - p0); end
    n_chk++; if (n_start - s0 !== 1 || n_hit - h0 !== 1) begin n_fail++; $display("FAIL wr_start_hit: got %0d/%0d want 1/1", n_start - s0, n_hit - h0); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_read;
    logic [7:0] g; logic a; int t0, k0, o0, p0;
    t0 = n_txreq; k0 = n_nack; p0 = n_stop;
    tx_data = 8'h96; tx_valid = 1'b1;
    do_start; do_byte(8'hA1, g); do_bit(1'b1, a);
    n_chk++; if (a !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack: got %b want 0", a); end
    do_byte(8'hFF, g);
    n_chk++; if (g !== 8'h96) begin n_fail++; $display("FAIL rd_byte0: got %h want 96", g); end
    tx_data = 8'h5A; do_bit(1'b0, a); do_byte(8'hFF, g);
    n_chk++; if (g !== 8'h5A) begin n_fail++; $display("FAIL rd_byte1: got %h want 5a", g); end
    do_bit(1'b1, a);
    n_chk++; if (n_nack - k0 !== 1) begin n_fail++; $display("FAIL rd_nack: got %0d want 1", n_nack - k0); end
    n_chk++; if (n_txreq - t0 !== 2) begin n_fail++; $display("FAIL rd_txreq: got %0d want 2", n_txreq - t0); end
    o0 = n_oe; do_byte(8'hFF, g);
    n_chk++; if (g !== 8'hFF || n_oe - o0 !== 0) begin n_fail++; $display("FAIL rd_ignore: got %h oe=%0d want ff oe=0", g, n_oe - o0); end
    do_stop;
    n_chk++; if (n_stop - p0 !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_stop: got %0d busy=%b want 1 busy=0", n_stop - p0, busy); end
  endtask

  task automatic test_bad_addr;
    logic [7:0] g; logic a; int h0, o0;
    h0 = n_hit; o0 = n_oe;
    do_start; do_byte(8'hA2, g); do_bit(1'b1, a);
    n_chk++; if (a !== 1'b1) begin n_fail++; $display("FAIL bad_ack: got %b want 1", a); end
    do_byte(8'h55, g); do_bit(1'b1, a);
    n_chk++; if (g !== 8'h55 || a !== 1'b1) begin n_fail++; $display("FAIL bad_data: got %h/%b want 55/1", g, a); end
    do_stop;
    n_chk++; if (n_hit - h0 !== 0) begin n_fail++; $display("FAIL bad_hit: got %0d want 0", n_hit - h0); end
    n_chk++; if (n_oe - o0 !== 0) begin n_fail++; $display("FAIL bad_oe: got %0d want 0", n_oe - o0); end
  endtask

  task automatic test_nack_data;
    logic [7:0] g; logic a; int v0;
    v0 = n_rxv;
    do_start; do_byte(8'hA0, g); do_bit(1'b1, a);
    n_chk++; if (a !== 1'b0) begin n_fail++; $display("FAIL nd_addr_ack: got %b want 0", a); end
    ack_en = 1'b0; do_byte(8'hC3, g); do_bit(1'b1, a);
    n_chk++; if (a !== 1'b1) begin n_fail++; $display("FAIL nd_data_nack: got %b want 1", a); end
    do_stop; ack_en = 1'b1;
    n_chk++; if (n_rxv - v0 !== 1 || last_rx !== 8'hC3) begin n_fail++; $display("FAIL nd_rx: got %0d/%h want 1/c3", n_rxv - v0, last_rx); end
  endtask

  task automatic test_rep_start;
    logic [7:0] g; logic a; int s0, h0, v0, k0;
    s0 = n_start; h0 = n_hit; v0 = n_rxv; k0 = n_nack;
    do_start; do_byte(8'hA0, g); do_bit(1'b1, a); do_byte(8'h11, g); do_bit(1'b1, a);
    tx_data = 8'hAB; tx_valid = 1'b0;
    do_start; do_byte(8'hA1, g); do_bit(1'b1, a);
    n_chk++; if (a !== 1'b0) begin n_fail++; $display("FAIL rs_addr_ack: got %b want 0", a); end
    do_byte(8'hFF, g);
    n_chk++; if (g !== 8'hFF) begin n_fail++; $display("FAIL rs_default: got %h want ff", g); end
    do_bit(1'b1, a); do_stop;
    n_chk++; if (n_start - s0 !== 2 || n_hit - h0 !== 2) begin n_fail++; $display("FAIL rs_start_hit: got %0d/%0d want 2/2", n_start - s0, n_hit - h0); end
    n_chk++; if (n_rxv - v0 !== 1 || n_nack - k0 !== 1) begin n_fail++; $display("FAIL rs_rx_nack: got %0d/%0d want 1/1", n_rxv - v0, n_nack - k0); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] g; logic a; int h0, o0;
    do_start; do_byte(8'hA0, g);
    m_sda = 1'b1; tick(5); scl_i = 1'b1; tick(3);
    n_chk++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rm_driving: got %b want 1", sda_oe); end
    reset = 1'b1; tick(1);
    n_chk++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_release: got oe=%b busy=%b want 0/0", sda_oe, busy); end
    reset = 1'b0; h0 = n_hit; o0 = n_oe;
    tick(1); scl_i = 1'b0; tick(5);
    do_byte(8'hA0, g); do_bit(1'b1, a);
    n_chk++; if (a !== 1'b1 || n_hit - h0 !== 0 || n_oe - o0 !== 0) begin
      n_fail++; $display("FAIL rm_idle: got ack=%b hit=%0d oe=%0d want 1/0/0", a, n_hit - h0, n_oe - o0);
    end
    do_stop;
  endtask

  task automatic test_random;
    logic [7:0] g, d, tx, exp_b, exp_last;
    logic [6:0] ad;
    logic a, rd, hit, ae, tv;
    int kind, nb, exp_rxv, h0, v0, t0, k0, p0;
    for (int t = 0; t < 10; t++) begin
      kind = int'($urandom_range(0, 2));
      nb = int'($urandom_range(1, 3));
      ad = kind == 2 ? 7'($urandom_range(0, 127)) : 7'h50;
      if (kind == 2 && ad == 7'h50) ad = 7'h51;
      rd = kind == 1;
      hit = ad == 7'h50;
      exp_rxv = 0; exp_last = 8'h00;
      h0 = n_hit; v0 = n_rxv; t0 = n_txreq; k0 = n_nack; p0 = n_stop;
      tv = 1'($urandom_range(0, 1)); tx = 8'($urandom);
      exp_b = tv ? tx : 8'hFF; tx_data = tx; tx_valid = tv;
      do_start; do_byte({ad, rd}, g); do_bit(1'b1, a);
      n_chk++; if (a !== ~hit) begin n_fail++; $display("FAIL rnd_addr_ack[%0d]: got %b want %b", t, a, ~hit); end
      for (int i = 0; i < nb; i++) begin
        if (!rd) begin
          d = 8'($urandom); ae = 1'($urandom_range(0, 1)); ack_en = ae;
          do_byte(d, g);
          n_chk++; if (g !== d) begin n_fail++; $display("FAIL rnd_wr_bus[%0d]: got %h want %h", t, g, d); end
          do_bit(1'b1, a);
          n_chk++; if (a !== ~(hit & ae)) begin n_fail++; $display("FAIL rnd_wr_ack[%0d]: got %b want %b", t, a, ~(hit & ae)); end
          if (hit) begin exp_rxv++; exp_last = d; end
        end else begin
          do_byte(8'hFF, g);
          n_chk++; if (g !== exp_b) begin n_fail++; $display("FAIL rnd_rd[%0d.%0d]: got %h want %h", t, i, g, exp_b); end
          if (i < nb - 1) begin
            tv = 1'($urandom_range(0, 1)); tx = 8'($urandom);
            exp_b = tv ? tx : 8'hFF; tx_data = tx; tx_valid = tv;
            do_bit(1'b0, a);
          end else do_bit(1'b1, a);
        end
      end
      do_stop; ack_en = 1'b1;
      n_chk++; if (n_hit - h0 !== int'(hit) || n_stop - p0 !== 1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rnd_frame[%0d]: got hit=%0d stop=%0d busy=%b want %0d/1/0", t, n_hit - h0, n_stop - p0, busy, hit);
      end
      n_chk++; if (n_rxv - v0 !== exp_rxv || (exp_rxv > 0 && last_rx !== exp_last)) begin
        n_fail++; $display("FAIL rnd_rx[%0d]: got %0d/%h want %0d/%h", t, n_rxv - v0, last_rx, exp_rxv, exp_last);
      end
      n_chk++; if (n_txreq - t0 !== (rd ? nb : 0) || n_nack - k0 !== int'(rd)) begin
        n_fail++; $display("FAIL rnd_rd_strobes[%0d]: got %0d/%0d want %0d/%0d", t, n_txreq - t0, n_nack - k0, rd ? nb : 0, rd);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_bad_addr;
    test_nack_data;
    test_rep_start;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_core.md
I2C_SLAVE_CORE -- requirements
Module: i2c_slave_core

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address this target responds to.
REQ-002 SHALL have parameter ACK_DATA_DEFAULT, default 1, the write-byte ACK policy used while ack_en is unused (tied high).
REQ-003 SHALL have ports (one clock; reset is synchronous and active-high):
 clk  in  1  system clock, at least 16x the SCL frequency
 reset  in  1  synchronous, active-high reset
 scl_i  in  1  SCL pin input (asynchronous)
 sda_i  in  1  SDA pin input (asynchronous)
 sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
 rx_data  out  8  last byte written by the master
 rx_valid  out  1  one-cycle strobe, rx_data is new
 ack_en  in  1  1 = ACK write data bytes; 0 = NACK them
 tx_data  in  8  byte to return on a master read
 tx_valid  in  1  tx_data is valid; sampled at load
 tx_req  out  1  one-cycle strobe requesting the next tx byte
 addr_hit  out  1  one-cycle strobe on address match
 start_det  out  1  one-cycle strobe on START or repeated START
 stop_det  out  1  one-cycle strobe on STOP
 nack_det  out  1  one-cycle strobe when the master NACKs a read byte
 busy  out  1  high from address match until STOP or return to IDLE

Function
REQ-004 SHALL pass scl_i and sda_i through 2-FF synchronisers, then one delay register each, and derive scl_rise, scl_fall, sda_rise and sda_fall from the synchronised signal and its delayed copy.
REQ-005 SHALL detect START as sda_fall while synchronised SCL is high, and STOP as sda_rise while synchronised SCL is high. Both SHALL take priority over all other events in the same cycle.
REQ-006 SHALL implement the states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and IGNORE.
REQ-007 On START in any state, the FSM SHALL go to ADDR, clear the bit counter, release sda_oe and pulse start_det.
REQ-008 On STOP in any state, the FSM SHALL go to IDLE, release sda_oe, pulse stop_det and drop busy.
REQ-009 SHALL sample SDA only on scl_rise and change sda_oe only on scl_fall, one clk after the edge is detected.
REQ-010 ADDR: SHALL shift in 8 bits MSB first on scl_rise.
 - After the 8th bit, upper 7 bits == SLAVE_ADDR: go to ADDR_ACK, pulse addr_hit, set busy, latch the R/W bit.
 - Otherwise: go to IGNORE with sda_oe held 0.
REQ-011 ADDR_ACK: SHALL assert sda_oe on the next scl_fall and hold it through the 9th SCL high.
 - On the scl_fall ending the ACK, R/W=0: go to WR_DATA with sda_oe released.
 - On the scl_fall ending the ACK, R/W=1: go to RD_DATA and drive bit 7 of the loaded tx byte.
REQ-012 WR_DATA: SHALL shift in 8 bits; on the 8th scl_rise, rx_data SHALL update and rx_valid SHALL pulse 1 clk later; then go to WR_ACK.
REQ-013 WR_ACK: SHALL drive sda_oe=1 during the ACK bit if ack_en=1 (sampled on the 8th scl_rise), otherwise release SDA (NACK); SHALL return to WR_DATA at the scl_fall ending the ACK.
REQ-014 tx_req SHALL pulse on the scl_rise of the 9th bit in ADDR_ACK (read) and on each RD_ACK scl_rise where the master ACKs.
REQ-015 The tx shift register SHALL load on the following scl_fall: tx_data if tx_valid=1, else 8'hFF.
REQ-016 RD_DATA: SHALL set sda_oe = ~shift[7] on each scl_fall and shift left after each scl_rise; after the 8th bit, release SDA at the scl_fall and go to RD_ACK.
REQ-017 RD_ACK: at the scl_rise, SDA=0 (ACK) SHALL continue to RD_DATA; SDA=1 (NACK) SHALL pulse nack_det and go to IGNORE.
REQ-018 IGNORE: sda_oe SHALL be 0; the FSM SHALL leave only on START or STOP.
REQ-019 The bit counter SHALL be 4 bits, count 0..8, and reset to 0 at every byte boundary. It SHALL never wrap past 8.
REQ-020 sda_oe SHALL never be asserted in IDLE or IGNORE; in any other state it SHALL be released within 1 clk of a START or STOP.

Reset
REQ-021 While reset=1 at a clk rising edge:
 - state=IDLE, sda_oe=0, all strobes=0, busy=0;
 - rx_data=8'h00, shift and counter registers cleared;
 - synchronisers preset to 1 (bus idle), so no false START/STOP is seen on release.
REQ-022 Reset asserted mid-transfer SHALL release SDA at the next clk edge and ignore the bus until the next START.

Verification
REQ-023 Write 0xA0 (addr 0x50, W), then data 0x3C, then STOP -> ACK on bits 9 and 18, rx_data=0x3C with one rx_valid pulse, stop_det pulse, busy=0.
REQ-024 Read 0xA1, tx_data=0x96 with tx_valid=1, master ACK, tx_data=0x5A, master NACK -> SDA bytes 0x96 then 0x5A, two tx_req pulses, one nack_det, then IGNORE until STOP.
REQ-025 Address 0x51 -> no ACK (SDA high on the 9th bit), no addr_hit, sda_oe=0 for the whole frame.
REQ-026 Write with ack_en=0 on the data byte -> address ACKed, data bit 9 NACKed, rx_valid still pulses.
REQ-027 Repeated START after a write byte, then 0xA1 read -> start_det pulses twice, R/W re-latched, read proceeds; tx_valid=0 yields 0xFF on SDA.
REQ-028 reset=1 while the target drives an ACK -> sda_oe=0 on the next clk, state=IDLE.
